// File: rtl/rom_loader_arbiter_if.sv
// Boot-loader byte stream, CPU and video read ports, and the single-port memory bus
// that rom_loader_arbiter drives. The slave modport is the arbiter's own view.
interface rom_loader_arbiter_if;
  logic [7:0]  load_data_i;
  logic        load_valid_i;
  logic        load_ready_o;
  logic        loaded_o;
  logic        cpu_req_i;
  logic [15:0] cpu_address_i;
  logic [7:0]  cpu_data_o;
  logic        cpu_ack_o;
  logic        vid_req_i;
  logic [15:0] vid_address_i;
  logic [7:0]  vid_data_o;
  logic        vid_ack_o;
  logic [15:0] mem_address_o;
  logic        mem_write_enable_o;
  logic [7:0]  mem_data_o;
  logic [7:0]  mem_data_i;

  modport slave (
    input  load_data_i, load_valid_i, cpu_req_i, cpu_address_i,
           vid_req_i, vid_address_i, mem_data_i,
    output load_ready_o, loaded_o, cpu_data_o, cpu_ack_o, vid_data_o, vid_ack_o,
           mem_address_o, mem_write_enable_o, mem_data_o
  );

  modport master (
    output load_data_i, load_valid_i, cpu_req_i, cpu_address_i,
           vid_req_i, vid_address_i, mem_data_i,
    input  load_ready_o, loaded_o, cpu_data_o, cpu_ack_o, vid_data_o, vid_ack_o,
           mem_address_o, mem_write_enable_o, mem_data_o
  );
endinterface

// File: rtl/rom_loader_arbiter.sv
// Boot loader that streams bytes into memory from address 0 up to LOAD_LAST, then
// arbitrates CPU and video reads round-robin over a registered (1-cycle) memory.
module rom_loader_arbiter #(
  parameter logic [15:0] LOAD_LAST = 16'hFFFF,
  parameter logic        SKIP_LOAD = 1'b0
) (
  input logic                 clock_i,
  input logic                 reset_i,
  rom_loader_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  localparam state_t RESET_STATE = SKIP_LOAD ? ST_IDLE : ST_LOAD;

  state_t      state_r;
  logic [15:0] load_ptr_r;
  logic        grant_vid_r;
  logic        last_vid_r;
  logic        load_ready_r;
  logic        loaded_r;
  logic [15:0] mem_address_r;
  logic        mem_we_r;
  logic [7:0]  mem_data_r;
  logic [7:0]  cpu_data_r;
  logic        cpu_ack_r;
  logic [7:0]  vid_data_r;
  logic        vid_ack_r;

  logic        cpu_elig_s;
  logic        vid_elig_s;
  logic        pick_vid_s;
  logic        load_accept_s;

  // A port whose ack is showing this cycle is finishing, not asking again.
  assign cpu_elig_s    = bus.cpu_req_i & ~cpu_ack_r;
  assign vid_elig_s    = bus.vid_req_i & ~vid_ack_r;
  assign pick_vid_s    = vid_elig_s & (~cpu_elig_s | ~last_vid_r);
  assign load_accept_s = (state_r == ST_LOAD) & bus.load_valid_i & load_ready_r;

  assign bus.load_ready_o       = load_ready_r;
  assign bus.loaded_o           = loaded_r;
  assign bus.mem_address_o      = mem_address_r;
  assign bus.mem_write_enable_o = mem_we_r;
  assign bus.mem_data_o         = mem_data_r;
  assign bus.cpu_data_o         = cpu_data_r;
  assign bus.cpu_ack_o          = cpu_ack_r;
  assign bus.vid_data_o         = vid_data_r;
  assign bus.vid_ack_o          = vid_ack_r;

  // Load / arbitration state machine with all outputs registered.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_r       <= RESET_STATE;
      load_ptr_r    <= 16'd0;
      grant_vid_r   <= 1'b0;
      last_vid_r    <= 1'b1;
      load_ready_r  <= 1'b0;
      loaded_r      <= SKIP_LOAD;
      mem_address_r <= 16'd0;
      mem_we_r      <= 1'b0;
      mem_data_r    <= 8'd0;
      cpu_data_r    <= 8'd0;
      cpu_ack_r     <= 1'b0;
      vid_data_r    <= 8'd0;
      vid_ack_r     <= 1'b0;
    end else begin
      mem_we_r  <= 1'b0;
      cpu_ack_r <= 1'b0;
      vid_ack_r <= 1'b0;
      case (state_r)
        ST_LOAD: begin
          if (load_accept_s) begin
            mem_address_r <= load_ptr_r;
            mem_data_r    <= bus.load_data_i;
            mem_we_r      <= 1'b1;
            if (load_ptr_r == LOAD_LAST) begin
              // Final byte: stop here so the pointer never wraps.
              state_r      <= ST_IDLE;
              loaded_r     <= 1'b1;
              load_ready_r <= 1'b0;
            end else begin
              load_ptr_r   <= load_ptr_r + 16'd1;
              load_ready_r <= 1'b1;
            end
          end else begin
            load_ready_r <= 1'b1;
          end
        end
        ST_IDLE: begin
          load_ready_r <= 1'b0;
          if (cpu_elig_s | vid_elig_s) begin
            grant_vid_r   <= pick_vid_s;
            last_vid_r    <= pick_vid_s;
            mem_address_r <= pick_vid_s ? bus.vid_address_i : bus.cpu_address_i;
            state_r       <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          load_ready_r <= 1'b0;
          state_r      <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          load_ready_r <= 1'b0;
          if (grant_vid_r) begin
            vid_data_r <= bus.mem_data_i;
            vid_ack_r  <= 1'b1;
          end else begin
            cpu_data_r <= bus.mem_data_i;
            cpu_ack_r  <= 1'b1;
          end
          state_r <= ST_IDLE;
        end
        default: begin
          load_ready_r <= 1'b0;
          state_r      <= RESET_STATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader_arbiter.sv
// Self-checking bench: boot load, round-robin read vectors, held request, reset
// during a read with a request pending over the reload, and the SKIP_LOAD variant.
module tb_rom_loader_arbiter;

  logic clock_i = 1'b0;
  logic reset_i = 1'b0;
  always #5 clock_i = ~clock_i;

  rom_loader_arbiter_if bus ();
  rom_loader_arbiter_if sbus ();

  rom_loader_arbiter #(.LOAD_LAST(16'd3), .SKIP_LOAD(1'b0)) u_dut (
    .clock_i(clock_i), .reset_i(reset_i), .bus(bus)
  );
  rom_loader_arbiter #(.LOAD_LAST(16'd3), .SKIP_LOAD(1'b1)) u_skip (
    .clock_i(clock_i), .reset_i(reset_i), .bus(sbus)
  );

  // Registered memories: a real 16-byte array for the main DUT, a fixed pattern for the skip DUT.
  logic [7:0] mem [0:15];
  always @(posedge clock_i) begin
    if (bus.mem_write_enable_o) mem[bus.mem_address_o[3:0]] <= bus.mem_data_o;
    bus.mem_data_i <= mem[bus.mem_address_o[3:0]];
  end
  always @(posedge clock_i) sbus.mem_data_i <= sbus.mem_address_o[7:0] ^ 8'h5A;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t        wr_q [$];
  logic [7:0] cpu_q [$];
  logic [7:0] vid_q [$];
  logic [7:0] cpu_last = 8'd0;
  logic [7:0] vid_last = 8'd0;
  logic [7:0] exp_mem [4];
  wr_t        wr_cur;

  // Scoreboard: write pulses and read acks are compared against queued expectations.
  always @(negedge clock_i) begin
    check("ack_overlap", 32'(bus.cpu_ack_o & bus.vid_ack_o), 32'd0);
    check("skip_no_write", 32'(sbus.mem_write_enable_o), 32'd0);
    if (reset_i) begin
      cpu_last = 8'd0;
      vid_last = 8'd0;
    end else begin
      if (bus.mem_write_enable_o) begin
        check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          wr_cur = wr_q.pop_front();
          check("wr_addr", 32'(bus.mem_address_o), 32'(wr_cur.a));
          check("wr_data", 32'(bus.mem_data_o), 32'(wr_cur.d));
        end
      end
      if (bus.cpu_ack_o) begin
        check("cpu_ack_expected", 32'(cpu_q.size() != 0), 32'd1);
        if (cpu_q.size() != 0) cpu_last = cpu_q.pop_front();
        check("cpu_data", 32'(bus.cpu_data_o), 32'(cpu_last));
        check("vid_hold", 32'(bus.vid_data_o), 32'(vid_last));
      end
      if (bus.vid_ack_o) begin
        check("vid_ack_expected", 32'(vid_q.size() != 0), 32'd1);
        if (vid_q.size() != 0) vid_last = vid_q.pop_front();
        check("vid_data", 32'(bus.vid_data_o), 32'(vid_last));
        check("cpu_hold", 32'(bus.cpu_data_o), 32'(cpu_last));
      end
    end
  end

  // Streams four bytes (MSB first) with an idle gap after byte index gap_after.
  task automatic load_stream(input logic [31:0] bytes, input int gap_after);
    logic [7:0] b;
    bit acc;
    for (int i = 0; i < 4; i++) begin
      b = bytes[31 - 8*i -: 8];
      exp_mem[i] = b;
      bus.load_data_i  = b;
      bus.load_valid_i = 1'b1;
      acc = 1'b0;
      for (int w = 0; w < 20 && !acc; w++) begin
        @(negedge clock_i);
        if (bus.load_ready_o) begin
          if (i == 3) check("loaded_before_last", 32'(bus.loaded_o), 32'd0);
          wr_q.push_back('{a: 16'(i), d: b});
          acc = 1'b1;
        end
        @(posedge clock_i); #1;
      end
      check("load_accept", 32'(acc), 32'd1);
      if (i == gap_after) begin
        bus.load_valid_i = 1'b0;
        repeat (2) begin @(posedge clock_i); #1; end
      end
    end
    check("loaded_after_last", 32'(bus.loaded_o), 32'd1);
    check("ready_after_last", 32'(bus.load_ready_o), 32'd0);
    bus.load_data_i = 8'hEE;
    repeat (2) begin @(posedge clock_i); #1; end
    check("ready_stays_low", 32'(bus.load_ready_o), 32'd0);
    bus.load_valid_i = 1'b0;
  endtask

  typedef struct {
    bit          use_cpu;
    logic [15:0] cpu_addr;
    int          cpu_lat;
    bit          use_vid;
    logic [15:0] vid_addr;
    int          vid_lat;
  } vec_t;
  vec_t vecs [6];

  task automatic run_vec(input vec_t v);
    int  cl, vl;
    bit  cdone, vdone;
    cl = 0; vl = 0;
    cdone = !v.use_cpu;
    vdone = !v.use_vid;
    if (v.use_cpu) begin
      bus.cpu_address_i = v.cpu_addr;
      bus.cpu_req_i     = 1'b1;
      cpu_q.push_back(exp_mem[v.cpu_addr[1:0]]);
    end
    if (v.use_vid) begin
      bus.vid_address_i = v.vid_addr;
      bus.vid_req_i     = 1'b1;
      vid_q.push_back(exp_mem[v.vid_addr[1:0]]);
    end
    for (int c = 1; c <= 20 && !(cdone && vdone); c++) begin
      @(posedge clock_i); #1;
      if (!cdone && bus.cpu_ack_o) begin cl = c; cdone = 1'b1; bus.cpu_req_i = 1'b0; end
      if (!vdone && bus.vid_ack_o) begin vl = c; vdone = 1'b1; bus.vid_req_i = 1'b0; end
    end
    bus.cpu_req_i = 1'b0;
    bus.vid_req_i = 1'b0;
    if (v.use_cpu) check("cpu_latency", 32'(cl), 32'(v.cpu_lat));
    if (v.use_vid) check("vid_latency", 32'(vl), 32'(v.vid_lat));
    @(posedge clock_i); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first, second, sl;
    // Reset is the initial grant "video", so the first contention goes to CPU.
    vecs[0] = '{1'b1, 16'd2, 3, 1'b0, 16'd0, 0};
    vecs[1] = '{1'b0, 16'd0, 0, 1'b1, 16'd1, 3};
    vecs[2] = '{1'b1, 16'd0, 3, 1'b1, 16'd3, 6};
    vecs[3] = '{1'b1, 16'd1, 3, 1'b1, 16'd2, 6};
    vecs[4] = '{1'b1, 16'd3, 3, 1'b0, 16'd0, 0};
    vecs[5] = '{1'b1, 16'd0, 6, 1'b1, 16'd1, 3};

    bus.load_data_i = 8'd0;  bus.load_valid_i = 1'b0;
    bus.cpu_req_i = 1'b0;    bus.cpu_address_i = 16'd0;
    bus.vid_req_i = 1'b0;    bus.vid_address_i = 16'd0;
    sbus.load_data_i = 8'd0; sbus.load_valid_i = 1'b0;
    sbus.cpu_req_i = 1'b0;   sbus.cpu_address_i = 16'd0;
    sbus.vid_req_i = 1'b0;   sbus.vid_address_i = 16'd0;

    #1 reset_i = 1'b1;
    #2;
    check("rst_ready", 32'(bus.load_ready_o), 32'd0);
    check("rst_loaded", 32'(bus.loaded_o), 32'd0);
    check("rst_mem_we", 32'(bus.mem_write_enable_o), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_address_o), 32'd0);
    check("rst_mem_data", 32'(bus.mem_data_o), 32'd0);
    check("rst_cpu_out", 32'({bus.cpu_data_o, bus.cpu_ack_o}), 32'd0);
    check("rst_vid_out", 32'({bus.vid_data_o, bus.vid_ack_o}), 32'd0);
    check("rst_skip_loaded", 32'(sbus.loaded_o), 32'd1);
    repeat (2) begin @(posedge clock_i); #1; end
    reset_i = 1'b0;

    // SKIP_LOAD instance: already loaded, never ready, serves a read immediately.
    @(posedge clock_i); #1;
    check("skip_loaded", 32'(sbus.loaded_o), 32'd1);
    check("skip_ready", 32'(sbus.load_ready_o), 32'd0);
    sbus.cpu_address_i = 16'h0007;
    sbus.cpu_req_i = 1'b1;
    sl = 0;
    for (int c = 1; c <= 20 && sl == 0; c++) begin
      @(posedge clock_i); #1;
      if (sbus.cpu_ack_o) sl = c;
    end
    sbus.cpu_req_i = 1'b0;
    check("skip_latency", 32'(sl), 32'd3);
    check("skip_data", 32'(sbus.cpu_data_o), 32'h5D);

    load_stream(32'h11223344, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Held request re-issues every four cycles.
    bus.cpu_address_i = 16'd0;
    bus.cpu_req_i = 1'b1;
    cpu_q.push_back(exp_mem[0]);
    cpu_q.push_back(exp_mem[0]);
    first = 0; second = 0;
    for (int c = 1; c <= 20 && second == 0; c++) begin
      @(posedge clock_i); #1;
      if (bus.cpu_ack_o) begin
        if (first == 0) first = c;
        else second = c;
      end
    end
    bus.cpu_req_i = 1'b0;
    check("held_first", 32'(first), 32'd3);
    check("held_second", 32'(second), 32'd7);
    repeat (2) begin @(posedge clock_i); #1; end

    // Reset while the read sits in ISSUE: no ack, load restarts at address 0.
    bus.cpu_address_i = 16'd1;
    bus.cpu_req_i = 1'b1;
    @(posedge clock_i); #1;
    reset_i = 1'b1;
    #1;
    check("mid_rst_loaded", 32'(bus.loaded_o), 32'd0);
    check("mid_rst_ready", 32'(bus.load_ready_o), 32'd0);
    check("mid_rst_mem_addr", 32'(bus.mem_address_o), 32'd0);
    repeat (2) begin @(posedge clock_i); #1; end
    check("mid_rst_no_ack", 32'(bus.cpu_ack_o), 32'd0);
    bus.cpu_address_i = 16'd2;
    cpu_q.push_back(8'hC3);
    reset_i = 1'b0;

    fork
      load_stream(32'hA1B2C3D4, 2);
      begin
        int  n0;
        bit  seen, got;
        n0 = 0; seen = 1'b0; got = 1'b0;
        for (int n = 1; n <= 80 && !got; n++) begin
          @(posedge clock_i); #1;
          if (!seen && bus.loaded_o) begin seen = 1'b1; n0 = n; end
          if (bus.cpu_ack_o) begin
            got = 1'b1;
            check("ack_after_load", 32'(seen), 32'd1);
            check("ack_idle_latency", 32'(n - n0), 32'd3);
            bus.cpu_req_i = 1'b0;
          end
        end
        check("pending_ack_seen", 32'(got), 32'd1);
      end
    join
    repeat (3) begin @(posedge clock_i); #1; end
    check("queues_drained", 32'(cpu_q.size() + vid_q.size() + wr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
